par_to_ser: RTL and testbench

PAR_TO_SER -- requirements
Module: par_to_ser

---
 rtl/gpu_pkg.sv | 11 +
 rtl/par_to_ser.sv | 129 ++++++++++++
 tb/tb_par_to_ser.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared package for the GPU datapath blocks.
// Holds the parallel-to-serial converter FSM state type.
package gpu_pkg;

  // IDLE: waiting for a beat; SHIFT: presenting words from the array.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

endpackage : gpu_pkg

// File: rtl/par_to_ser.sv
// par_to_ser: accepts a beat of up to DEPTH packed words and emits them one
// word per output transfer, lowest word first.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   rst        synchronous active-high reset
//   clk_en     global advance enable; low freezes all state and transfers
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat this cycle
//   in_data    packed words, word k = in_data[k*WIDTH +: WIDTH]
//   in_count   valid words in the beat (values above DEPTH clamp to DEPTH)
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts the word
//   out_data   current word (array slot 0)
//   out_last   current word is the final word of its beat
//   busy       high while shifting out a beat
module par_to_ser
  import gpu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*DEPTH-1:0]     in_data,
  input  logic [$clog2(DEPTH+1)-1:0] in_count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  p2s_state_t       state_r;
  logic [CW-1:0]    remaining_r;
  logic [WIDTH-1:0] words_r [DEPTH];

  logic             accept_s;
  logic             xfer_s;
  logic [CW-1:0]    count_s;

  // Beats may claim more words than the array holds; never shift past it.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    if (c > DEPTH_C) begin
      return DEPTH_C;
    end else begin
      return c;
    end
  endfunction

  // Outputs come straight from state registers: slot 0 is always the head word.
  assign out_valid = (state_r == SHIFT);
  assign busy      = (state_r == SHIFT);
  assign out_last  = (state_r == SHIFT) && (remaining_r == ONE_C);
  assign out_data  = words_r[0];

  // A new beat may enter while the final word leaves, giving gapless streaming.
  // in_ready is held low during reset so nothing is accepted into a clearing block.
  assign in_ready = clk_en && !rst &&
                    ((state_r == IDLE) || (out_valid && out_ready && out_last));

  assign accept_s = in_valid && in_ready;
  assign xfer_s   = clk_en && out_valid && out_ready;
  assign count_s  = clamp_count(in_count);

  // Converter FSM with word array: parallel load on accept, shift-down on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= ZERO_C;
      for (int k = 0; k < DEPTH; k++) begin
        words_r[k] <= WIDTH'(0);
      end
    end else if (clk_en) begin
      case (state_r)
        IDLE: begin
          // Zero-count beats are consumed with no effect.
          if (accept_s && (count_s != ZERO_C)) begin
            for (int k = 0; k < DEPTH; k++) begin
              words_r[k] <= in_data[k*WIDTH +: WIDTH];
            end
            remaining_r <= count_s;
            state_r     <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (accept_s && (count_s != ZERO_C)) begin
            // Only reachable while the last word transfers: reload in place.
            for (int k = 0; k < DEPTH; k++) begin
              words_r[k] <= in_data[k*WIDTH +: WIDTH];
            end
            remaining_r <= count_s;
            state_r     <= SHIFT;
          end else if (xfer_s) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
              words_r[k] <= words_r[k+1];
            end
            words_r[DEPTH-1] <= WIDTH'(0);
            remaining_r      <= remaining_r - ONE_C;
            if (remaining_r == ONE_C) begin
              state_r <= IDLE;
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r     <= IDLE;
          remaining_r <= ZERO_C;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule : par_to_ser

// File: tb/tb_par_to_ser.sv
// Scoreboard bench for par_to_ser (WIDTH=8, DEPTH=4). The driver pushes the
// words each accepted beat should produce; the monitor pops and compares on
// every output transfer and checks handshake/valid behaviour every cycle.
module tb_par_to_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  bit   rand_mode = 1'b0;

  par_to_ser #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a beat yields its first min(count,4) words, lowest first.
  task automatic push_beat(input logic [31:0] d, input int c);
    int n;
    exp_t e;
    n = (c > 4) ? 4 : c;
    for (int i = 0; i < n; i++) begin
      e.data = 8'((d >> (8 * i)) & 32'hFF);
      e.last = (i == n - 1);
      q.push_back(e);
    end
  endtask

  // Present a beat until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [2:0] c);
    int budget = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_count = c;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (acc) begin
      push_beat(d, int'(c));
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic drain();
    int budget = 0;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: per-cycle handshake checks and scoreboard pop on transfers.
  always @(negedge clk) begin
    bit ev;
    bit er;
    if (mon_en && !rst) begin
      ev = (q.size() > 0);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(ev));
      if (ev) begin
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_last", 32'(out_last), 32'(q[0].last));
        er = clk_en && out_ready && q[0].last;
      end else begin
        er = clk_en;
      end
      chk("in_ready", 32'(in_ready), 32'(er));
      if (clk_en && out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
      end
    end
  end

  // Random backpressure and enable pattern.
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clk_en    = ($urandom_range(0, 4) != 0);
    end
  end

  initial begin
    int rdy_pat [8];
    int en_pat  [8];
    rdy_pat = '{1, 0, 0, 1, 1, 1, 1, 1};
    en_pat  = '{1, 1, 1, 0, 0, 1, 1, 1};

    rst = 1'b1; clk_en = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    in_count = 3'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    clk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clk_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clk_en = 1'b1; out_ready = 1'b1;
    mon_en = 1'b1;

    // Full beat, then partial beat (upper words must never appear).
    send_beat(32'h44332211, 3'd4);
    drain();
    chk("busy_after", 32'(busy), 32'd0);
    send_beat(32'hDDCCBBAA, 3'd2);
    drain();

    // Back-to-back beats held valid: gapless seven words.
    send_beat(32'h44332211, 3'd4);
    send_beat(32'h00776655, 3'd3);
    drain();

    // Stalls from out_ready and clk_en mid-beat.
    send_beat(32'h87654321, 3'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_ready = rdy_pat[i][0];
      clk_en    = en_pat[i][0];
      @(posedge clk); #1;
    end
    out_ready = 1'b1; clk_en = 1'b1;
    drain();

    // Reset after two of four words.
    send_beat(32'hA4A3A2A1, 3'd4);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    send_beat(32'h0000005A, 3'd1);
    drain();

    // Zero-count beat is swallowed; clamped count beat emits four words.
    send_beat(32'h12345678, 3'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("zero_busy", 32'(busy), 32'd0);
    send_beat(32'hF3F2F1F0, 3'd7);
    drain();

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int b = 0; b < 150; b++) begin
      send_beat($urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; clk_en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_par_to_ser
